// File: rtl/pcie_pkg.sv
// Shared definitions for the transaction-layer flow controller: sizes,
// destination field position and FSM state encodings.
package pcie_pkg;

  localparam int DATA_W   = 12;
  localparam int NUM_Q    = 4;
  localparam int UMBRAL_W = 4;
  localparam int Q_IDX_W  = 2;
  localparam int DEST_MSB = DATA_W - 1;
  localparam int DEST_LSB = DATA_W - 2;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  // Destination FIFO index carried in the two MSBs of every word.
  function automatic logic [Q_IDX_W-1:0] dest_of(input logic [DATA_W-1:0] word);
    return word[DEST_MSB:DEST_LSB];
  endfunction

endpackage

// File: rtl/pcie_flow_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requesting index strictly after ptr,
// wrapping from N-1 back to 0, so the last winner has lowest priority.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  // Scan N candidates starting one past the pointer; first hit wins.
  always_comb begin
    int cand;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
    grant = grant_valid ? (N'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/pcie_flow_ctrl.sv
// Flow controller: round-robin pops source FIFOs, steers each word to the
// destination FIFO named in its MSBs, skips destinations that are almost
// full, and owns the main FSM plus the thresholds distributed to all FIFOs.
//
// Handshake: a source FIFO head is valid when fifo_empty[i]=0 and is consumed
// in the cycle pop[i]=1 (first-word-fall-through). The popped word appears on
// data_out with dest_push one cycle later; destinations accept unconditionally,
// dest_almost_full is the only back-pressure and is honoured before popping.
module pcie_flow_ctrl
  import pcie_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      init,
  input  logic [UMBRAL_W-1:0]       umbral_L_in,
  input  logic [UMBRAL_W-1:0]       umbral_H_in,
  input  logic [NUM_Q-1:0]          fifo_empty,
  input  logic [NUM_Q*DATA_W-1:0]   fifo_data,
  input  logic [NUM_Q-1:0]          fifo_error,
  input  logic [NUM_Q-1:0]          dest_almost_full,
  output logic [NUM_Q-1:0]          pop,
  output logic [NUM_Q-1:0]          dest_push,
  output logic [DATA_W-1:0]         data_out,
  output logic [UMBRAL_W-1:0]       umbral_L,
  output logic [UMBRAL_W-1:0]       umbral_H,
  output logic [2:0]                state,
  output logic                      idle_out,
  output logic                      active_out,
  output logic                      error_out
);

  state_t              st, st_nxt;
  logic [Q_IDX_W-1:0]  rr_ptr;
  logic [NUM_Q-1:0]    eligible;
  logic [NUM_Q-1:0]    grant;
  logic [Q_IDX_W-1:0]  grant_idx;
  logic                grant_valid;
  logic                arb_en;
  logic                any_error;
  logic                all_empty;
  logic [DATA_W-1:0]   grant_word;

  assign any_error = |fifo_error;
  assign all_empty = &fifo_empty;

  // A queue may be served only if it has a word and that word's destination has room.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      eligible[i] = !fifo_empty[i] &&
                    !dest_almost_full[dest_of(fifo_data[i*DATA_W +: DATA_W])];
    end
  end

  rr_arbiter #(.N(NUM_Q), .IDX_W(Q_IDX_W)) u_arb (
    .req         (eligible),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Pops are suppressed in the very cycle the FSM leaves ACTIVE for ERROR or INIT.
  assign arb_en     = (st == ST_ACTIVE) && !any_error && !init;
  assign grant_word = fifo_data[grant_idx*DATA_W +: DATA_W];

  // Gate the arbiter grant onto the pop outputs.
  always_comb begin
    pop = '0;
    if (arb_en && grant_valid) pop = grant;
  end

  // Next-state logic; error has priority over init, ERROR only leaves via reset.
  always_comb begin
    st_nxt = st;
    case (st)
      ST_RESET:  st_nxt = ST_INIT;
      ST_INIT: begin
        if (any_error)  st_nxt = ST_ERROR;
        else if (!init) st_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (any_error)       st_nxt = ST_ERROR;
        else if (init)       st_nxt = ST_INIT;
        else if (!all_empty) st_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (any_error)                         st_nxt = ST_ERROR;
        else if (init)                         st_nxt = ST_INIT;
        else if (all_empty && dest_push == '0) st_nxt = ST_IDLE;
      end
      ST_ERROR:  st_nxt = ST_ERROR;
      default:   st_nxt = ST_ERROR;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= ST_RESET;
    else       st <= st_nxt;
  end

  // Thresholds follow the inputs for as long as the FSM sits in INIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      umbral_L <= '0;
      umbral_H <= '0;
    end else if (st == ST_INIT) begin
      umbral_L <= umbral_L_in;
      umbral_H <= umbral_H_in;
    end
  end

  // Round-robin pointer remembers the last granted queue; starts so queue 0 goes first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      rr_ptr <= Q_IDX_W'(NUM_Q - 1);
    else if (arb_en && grant_valid) rr_ptr <= grant_idx;
  end

  // Output stage: popped word is pushed to its destination one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dest_push <= '0;
      data_out  <= '0;
    end else if (arb_en && grant_valid) begin
      dest_push <= NUM_Q'(1) << dest_of(grant_word);
      data_out  <= grant_word;
    end else begin
      dest_push <= '0;
    end
  end

  assign state      = st;
  assign idle_out   = (st == ST_IDLE);
  assign active_out = (st == ST_ACTIVE);
  assign error_out  = (st == ST_ERROR);

endmodule
